// File: rtl/load_store_unit.sv
// load_store_unit: single-access load/store engine with a req/ack data-memory port.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned half/word instead of force-aligning.
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Base,
  input  logic [31:0] Imm_Ext,
  input  logic [31:0] WD,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic        Misaligned,
  output logic [31:0] RD,
  output logic        Mem_Req,
  input  logic        Mem_Ack,
  output logic        Mem_WE,
  output logic [3:0]  Mem_BE,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WD,
  input  logic [31:0] Mem_RD
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  localparam int CW =
    (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'(ACK_TIMEOUT - 1);

  state_t        state;
  size_t         lat_size;
  logic          lat_sign;
  logic          lat_load;
  logic [1:0]    lat_off;
  logic [CW-1:0] cnt;

  logic [31:0] ea;
  size_t       f_size;
  logic        f_sign;
  logic [1:0]  f_off;
  logic [3:0]  f_be;
  logic [31:0] f_wd;
  logic        trap;

  assign ea = Base + Imm_Ext;

  // Undefined encodings, and unsigned codes on stores, fall back to word.
  always_comb begin
    f_size = SZ_W;
    f_sign = 1'b0;
    case (Funct3)
      3'b000: begin
        f_size = SZ_B;
        f_sign = 1'b1;
      end
      3'b001: begin
        f_size = SZ_H;
        f_sign = 1'b1;
      end
      3'b100: begin
        if (!MemWrite) f_size = SZ_B;
      end
      3'b101: begin
        if (!MemWrite) f_size = SZ_H;
      end
      default: ;
    endcase
  end

  always_comb begin
    f_off = 2'b00;
    f_be  = 4'b1111;
    f_wd  = WD;
    unique case (1'b1)
      f_size == SZ_B: begin
        f_off = ea[1:0];
        f_be  = 4'b0001 << ea[1:0];
        f_wd  = {4{WD[7:0]}};
      end
      f_size == SZ_H: begin
        f_off = {ea[1], 1'b0};
        f_be  = 4'b0011 << {ea[1], 1'b0};
        f_wd  = {2{WD[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (f_size == SZ_H && ea[0]) ||
                (f_size == SZ_W && ea[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic [31:0] ld_val;

  always_comb begin
    case (lat_off)
      2'd0:    rd_b = Mem_RD[7:0];
      2'd1:    rd_b = Mem_RD[15:8];
      2'd2:    rd_b = Mem_RD[23:16];
      default: rd_b = Mem_RD[31:24];
    endcase
    rd_h   = lat_off[1] ? Mem_RD[31:16] : Mem_RD[15:0];
    ld_val = Mem_RD;
    unique case (1'b1)
      lat_size == SZ_B:
        ld_val = {{24{lat_sign & rd_b[7]}}, rd_b};
      lat_size == SZ_H:
        ld_val = {{16{lat_sign & rd_h[15]}}, rd_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
      Misaligned <= 1'b0;
      RD         <= '0;
      Mem_Req    <= 1'b0;
      Mem_WE     <= 1'b0;
      Mem_BE     <= '0;
      Mem_Addr   <= '0;
      Mem_WD     <= '0;
      lat_size   <= SZ_W;
      lat_sign   <= 1'b0;
      lat_load   <= 1'b0;
      lat_off    <= '0;
      cnt        <= '0;
    end else begin
      Done       <= 1'b0;
      Err        <= 1'b0;
      Misaligned <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
          if (Start) begin
            if (trap) begin
              state      <= DONE;
              Done       <= 1'b1;
              Misaligned <= 1'b1;
            end else begin
              state    <= REQ;
              Busy     <= 1'b1;
              Mem_Req  <= 1'b1;
              Mem_WE   <= MemWrite;
              Mem_BE   <= f_be;
              Mem_Addr <= {ea[31:2], 2'b00};
              Mem_WD   <= f_wd;
              lat_size <= f_size;
              lat_sign <= f_sign;
              lat_load <= !MemWrite;
              lat_off  <= f_off;
              cnt      <= '0;
            end
          end
        end
        REQ: begin
          if (Mem_Ack) begin
            state   <= DONE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            Mem_Req <= 1'b0;
            if (lat_load) RD <= ld_val;
          end else if (cnt == LIMIT) begin
            state   <= DONE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            Err     <= 1'b1;
            Mem_Req <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          Busy    <= 1'b0;
          Mem_Req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit handshake,
// lane selection, store replication, timeout, misalignment and reset.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        Start;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Base;
  logic [31:0] Imm_Ext;
  logic [31:0] WD;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic        Misaligned;
  logic [31:0] RD;
  logic        Mem_Req;
  logic        Mem_Ack;
  logic        Mem_WE;
  logic [3:0]  Mem_BE;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WD;
  logic [31:0] Mem_RD;

  int checks;
  int failures;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .Start      (Start),
    .MemWrite   (MemWrite),
    .Funct3     (Funct3),
    .Base       (Base),
    .Imm_Ext    (Imm_Ext),
    .WD         (WD),
    .Busy       (Busy),
    .Done       (Done),
    .Err        (Err),
    .Misaligned (Misaligned),
    .RD         (RD),
    .Mem_Req    (Mem_Req),
    .Mem_Ack    (Mem_Ack),
    .Mem_WE     (Mem_WE),
    .Mem_BE     (Mem_BE),
    .Mem_Addr   (Mem_Addr),
    .Mem_WD     (Mem_WD),
    .Mem_RD     (Mem_RD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access with ack on the first REQ cycle.
  task automatic do_access(
    string       tag,
    logic        we,
    logic [2:0]  f3,
    logic [31:0] base,
    logic [31:0] imm,
    logic [31:0] wdata,
    logic [31:0] rdata,
    logic [31:0] exp_addr,
    logic [3:0]  exp_be,
    logic [31:0] exp_wd,
    logic [31:0] exp_rd
  );
    MemWrite = we;
    Funct3   = f3;
    Base     = base;
    Imm_Ext  = imm;
    WD       = wdata;
    Mem_RD   = rdata;
    Start    = 1'b1;
    step();
    Start = 1'b0;
    chk1({tag, "_req"}, Mem_Req, 1'b1);
    chk1({tag, "_busy"}, Busy, 1'b1);
    chk1({tag, "_done_early"}, Done, 1'b0);
    chk32({tag, "_addr"}, Mem_Addr, exp_addr);
    chk4({tag, "_be"}, Mem_BE, exp_be);
    chk1({tag, "_we"}, Mem_WE, we);
    chk32({tag, "_wd"}, Mem_WD, exp_wd);
    Mem_Ack = 1'b1;
    step();
    Mem_Ack = 1'b0;
    chk1({tag, "_done"}, Done, 1'b1);
    chk1({tag, "_err"}, Err, 1'b0);
    chk1({tag, "_mis"}, Misaligned, 1'b0);
    chk1({tag, "_req_drop"}, Mem_Req, 1'b0);
    chk1({tag, "_busy_drop"}, Busy, 1'b0);
    chk32({tag, "_rd"}, RD, exp_rd);
    step();
    chk1({tag, "_done_pulse"}, Done, 1'b0);
  endtask

  logic early_done;

  initial begin
    checks     = 0;
    failures   = 0;
    early_done = 1'b0;
    rst        = 1'b0;
    Start      = 1'b0;
    MemWrite   = 1'b0;
    Funct3     = 3'b010;
    Base       = '0;
    Imm_Ext    = '0;
    WD         = '0;
    Mem_Ack    = 1'b0;
    Mem_RD     = '0;
    step();
    step();

    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_done", Done, 1'b0);
    chk1("rst_err", Err, 1'b0);
    chk1("rst_mis", Misaligned, 1'b0);
    chk1("rst_req", Mem_Req, 1'b0);
    chk1("rst_we", Mem_WE, 1'b0);
    chk4("rst_be", Mem_BE, 4'b0000);
    chk32("rst_addr", Mem_Addr, 32'h0);
    chk32("rst_wd", Mem_WD, 32'h0);
    chk32("rst_rd", RD, 32'h0);

    rst = 1'b1;
    step();

    // LW with wrapping EA, minimum latency
    do_access("lw_wrap", 1'b0, 3'b010, 32'h100, 32'hFFFF_FFFC,
              32'h0, 32'hDEAD_BEEF,
              32'h0000_00FC, 4'b1111, 32'h0, 32'hDEAD_BEEF);

    do_access("lb_hi", 1'b0, 3'b000, 32'h200, 32'h3,
              32'h0, 32'h80FF_FFFF,
              32'h0000_0200, 4'b1000, 32'h0, 32'hFFFF_FF80);
    do_access("lbu_hi", 1'b0, 3'b100, 32'h200, 32'h3,
              32'h0, 32'h80FF_FFFF,
              32'h0000_0200, 4'b1000, 32'h0, 32'h0000_0080);

    do_access("sh_o2", 1'b1, 3'b001, 32'h0, 32'h2,
              32'h1234_ABCD, 32'h0,
              32'h0000_0000, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080);
    do_access("sb_o1", 1'b1, 3'b000, 32'h100, 32'h1,
              32'hFFFF_FF55, 32'h0,
              32'h0000_0100, 4'b0010, 32'h5555_5555, 32'h0000_0080);

    do_access("lh_o2", 1'b0, 3'b001, 32'h40, 32'h2,
              32'h0, 32'h8001_1234,
              32'h0000_0040, 4'b1100, 32'h0, 32'hFFFF_8001);
    do_access("lhu_o2", 1'b0, 3'b101, 32'h40, 32'h2,
              32'h0, 32'h8001_1234,
              32'h0000_0040, 4'b1100, 32'h0, 32'h0000_8001);

    // Store 1xx falls back to word
    do_access("s_f3_110", 1'b1, 3'b110, 32'h20, 32'h1,
              32'h0BAD_F00D, 32'h0,
              32'h0000_0020, 4'b1111, 32'h0BAD_F00D, 32'h0000_8001);

    // Back-to-back: new Start accepted in the DONE cycle
    MemWrite = 1'b1;
    Funct3   = 3'b010;
    Base     = 32'h10;
    Imm_Ext  = 32'h0;
    WD       = 32'hCAFE_F00D;
    Start    = 1'b1;
    step();
    Start   = 1'b0;
    Mem_Ack = 1'b1;
    step();
    chk1("b2b_done1", Done, 1'b1);
    Mem_Ack  = 1'b0;
    MemWrite = 1'b0;
    Mem_RD   = 32'h1122_3344;
    Start    = 1'b1;
    step();
    Start = 1'b0;
    chk1("b2b_req2", Mem_Req, 1'b1);
    chk1("b2b_we2", Mem_WE, 1'b0);
    chk1("b2b_done_gap", Done, 1'b0);
    Mem_Ack = 1'b1;
    step();
    Mem_Ack = 1'b0;
    chk1("b2b_done2", Done, 1'b1);
    chk32("b2b_rd", RD, 32'h1122_3344);
    step();

    // Ack timeout with a Start pulse in the middle of REQ
    MemWrite = 1'b0;
    Funct3   = 3'b010;
    Base     = 32'h40;
    Imm_Ext  = 32'h0;
    Mem_RD   = 32'h5555_AAAA;
    Start    = 1'b1;
    step();
    for (int k = 1; k < 255; k++) begin
      if (Done || !Mem_Req) early_done = 1'b1;
      Start = (k == 100);
      Base  = (k == 100) ? 32'h800 : 32'h40;
      step();
    end
    Start = 1'b0;
    chk1("to_no_early_end", early_done, 1'b0);
    chk1("to_req_last", Mem_Req, 1'b1);
    chk1("to_busy_last", Busy, 1'b1);
    chk32("to_addr_kept", Mem_Addr, 32'h0000_0040);
    step();
    chk1("to_req_drop", Mem_Req, 1'b0);
    chk1("to_done", Done, 1'b1);
    chk1("to_err", Err, 1'b1);
    chk1("to_busy", Busy, 1'b0);
    chk32("to_rd_kept", RD, 32'h1122_3344);
    step();
    chk1("to_done_pulse", Done, 1'b0);
    chk1("to_err_pulse", Err, 1'b0);

    // Misaligned LW at EA=0x06
`ifdef LSU_MISALIGN_TRAP_EN
    MemWrite = 1'b0;
    Funct3   = 3'b010;
    Base     = 32'h4;
    Imm_Ext  = 32'h2;
    Mem_RD   = 32'hA5A5_0F0F;
    Start    = 1'b1;
    step();
    Start = 1'b0;
    chk1("mis_no_req", Mem_Req, 1'b0);
    chk1("mis_done", Done, 1'b1);
    chk1("mis_flag", Misaligned, 1'b1);
    chk1("mis_busy", Busy, 1'b0);
    chk32("mis_rd_kept", RD, 32'h1122_3344);
    step();
    chk1("mis_flag_pulse", Misaligned, 1'b0);
`else
    do_access("lw_mis", 1'b0, 3'b010, 32'h4, 32'h2,
              32'h0, 32'hA5A5_0F0F,
              32'h0000_0004, 4'b1111, 32'h0, 32'hA5A5_0F0F);
`endif

    // Reset in the middle of REQ, colliding with Ack and Start
    MemWrite = 1'b0;
    Funct3   = 3'b010;
    Base     = 32'h300;
    Imm_Ext  = 32'h0;
    Start    = 1'b1;
    step();
    Start = 1'b0;
    chk1("rmid_req", Mem_Req, 1'b1);
    rst     = 1'b0;
    Mem_Ack = 1'b1;
    Start   = 1'b1;
    step();
    chk1("rmid_req_drop", Mem_Req, 1'b0);
    chk1("rmid_busy", Busy, 1'b0);
    chk1("rmid_done", Done, 1'b0);
    chk1("rmid_err", Err, 1'b0);
    chk1("rmid_we", Mem_WE, 1'b0);
    chk4("rmid_be", Mem_BE, 4'b0000);
    chk32("rmid_addr", Mem_Addr, 32'h0);
    chk32("rmid_wd", Mem_WD, 32'h0);
    chk32("rmid_rd", RD, 32'h0);
    rst     = 1'b1;
    Mem_Ack = 1'b0;
    Start   = 1'b0;
    step();
    chk1("rmid_no_done", Done, 1'b0);
    chk1("rmid_idle", Mem_Req, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: max cycles in REQ without Mem_Ack before abort.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port Start  in  1  request to begin one access.
REQ-005 SHALL have port MemWrite  in  1  1 = store, 0 = load.
REQ-006 SHALL have port Funct3  in  3  access width and sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-007 SHALL have ports Base, Imm_Ext, WD  in  32 each  rs1 value, sign-extended immediate, and store data.
REQ-008 SHALL have ports Busy, Done, Err, Misaligned  out  1 each  status; Done, Err and Misaligned are pulses.
REQ-009 SHALL have port RD  out  32  load result.
REQ-010 SHALL have ports Mem_Req out 1, Mem_Ack in 1, Mem_WE out 1, Mem_BE out 4, Mem_Addr out 32, Mem_WD out 32, Mem_RD in 32  data-memory handshake.

Function
REQ-011 SHALL implement FSM with states IDLE, REQ and DONE.
REQ-012 SHALL accept Start only in IDLE or DONE; in that cycle latch EA = (Base + Imm_Ext) mod 2^32, MemWrite, Funct3 and WD, then enter REQ.
REQ-013 SHALL ignore Start while in REQ.
REQ-014 SHALL hold Busy=1 exactly while in REQ.
REQ-015 SHALL in REQ drive Mem_Req=1 with Mem_Addr={EA[31:2],2'b00}, Mem_WE=latched MemWrite, Mem_BE and Mem_WD stable until Mem_Ack.
REQ-016 SHALL complete the transfer on the edge where Mem_Req=1 and Mem_Ack=1, then enter DONE.
REQ-017 SHALL drop Mem_Req in the cycle after the ack.
REQ-018 SHALL give a minimum latency of Start at cycle 0, Mem_Req at 1, Ack at 1, Done at 2.
REQ-019 SHALL pulse Done=1 for exactly one cycle in DONE, then return to IDLE unless Start is asserted.
REQ-020 SHALL set store byte enables by offset o=EA[1:0]: byte 4'b0001<<o, half 4'b0011<<o, word 4'b1111.
REQ-021 SHALL replicate store data: byte {4{WD[7:0]}}, half {2{WD[15:0]}}, word WD.
REQ-022 SHALL on a load capture Mem_RD at ack and select lane o; byte/half sign-extended for 000/001, zero-extended for 100/101; word passed unchanged.
REQ-023 SHALL update RD only on a load completion and hold it otherwise; stores leave RD unchanged.
REQ-024 SHALL treat undefined Funct3 values (011, 110, 111, and store 1xx) as word accesses.
REQ-025 SHALL, when ACK_TIMEOUT consecutive REQ cycles pass without Mem_Ack, drop Mem_Req, leave RD unchanged, and pulse Done=1 and Err=1 together.
REQ-026 SHALL treat Mem_Ack outside REQ as ignored.

Reset
REQ-027 SHALL on rst=0 at a clock edge enter IDLE and clear Busy, Done, Err, Misaligned, Mem_Req, Mem_WE, Mem_BE, Mem_Addr, Mem_WD, RD and the timeout counter to 0.
REQ-028 SHALL on reset mid-REQ drop Mem_Req at that edge and produce no Done for the aborted access.
REQ-029 SHALL give reset priority over Start and Mem_Ack in the same cycle.

Configuration
REQ-030 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat half with EA[0]=1 or word with EA[1:0]!=0 as misaligned: no Mem_Req, next cycle DONE with Done=1 and Misaligned=1, RD unchanged.
REQ-031 SHALL, without LSU_MISALIGN_TRAP_EN, tie Misaligned to 0, force the offending low EA bits to 0 (half: o&2'b10, word: 2'b00) and perform the access normally.

Verification
REQ-032 SHALL cover: Base=0x100, Imm_Ext=0xFFFFFFFC, LW, Ack on first REQ cycle -> Mem_Addr=0xFC, Mem_BE=1111, Done at cycle 2, RD=Mem_RD.
REQ-033 SHALL cover: LB at EA=0x203 with Mem_RD=0x80FF_FFFF -> RD=0xFFFFFF80; same access as LBU -> RD=0x00000080.
REQ-034 SHALL cover: SH at EA=0x02, WD=0x1234ABCD -> Mem_BE=1100, Mem_WD=0xABCDABCD, Mem_WE=1, RD unchanged.
REQ-035 SHALL cover: Mem_Ack held low 255 cycles -> Mem_Req drops, Done=1 and Err=1 for one cycle; Start pulsed mid-REQ ignored.
REQ-036 SHALL cover: LW at EA=0x06 -> with macro, Misaligned=1 and no Mem_Req; without macro, Mem_Addr=0x04 and Mem_BE=1111.
REQ-037 SHALL cover: rst=0 during REQ -> Mem_Req=0 at next edge, no Done, all outputs 0.
